// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared owner encoding and burst counter sizing for dm_arbiter
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } owner_e;

  // Counter wide enough to hold MAX_BURST itself, not just MAX_BURST-1
  function automatic int burst_cnt_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/dm_arb_burst_ctr.sv
// rtl/dm_arb_burst_ctr.sv - locked-burst transfer counter with limit flag
module dm_arb_burst_ctr
  import dm_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int CW = burst_cnt_width(MAX_BURST);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  logic [CW-1:0] cnt;

  // Count transfers of the current locked burst; clear has priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

  // High when the transfer happening now would be the last one the burst may take
  assign at_limit = (cnt >= LAST);

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin two-port arbiter for the single-port data memory
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  lock0,
  input  logic                  wr0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  lock1,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  owner_e owner, owner_nxt;
  logic   last_served, last_served_nxt;
  logic   rd_pend, rd_tag;
  logic   burst_clr, burst_inc, burst_limit;

  // View of the current owner's side and its competitor, valid in OWN states
  logic   own_is1, own_req, own_lock, oth_req;
  owner_e oth_state;

  assign own_is1   = (owner == ST_OWN1);
  assign own_req   = own_is1 ? req1 : req0;
  assign own_lock  = own_is1 ? lock1 : lock0;
  assign oth_req   = own_is1 ? req0 : req1;
  assign oth_state = own_is1 ? ST_OWN0 : ST_OWN1;

  assign gnt0   = req0 & (owner == ST_OWN0);
  assign gnt1   = req1 & (owner == ST_OWN1);
  assign mem_en = gnt0 | gnt1;

  // Present the owner's command to memory; all zero while nobody owns the port
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr    = 1'b0;
    case (owner)
      ST_OWN0: begin
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_wr    = gnt0 & wr0;
      end
      ST_OWN1: begin
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_wr    = gnt1 & wr1;
      end
      default: ;
    endcase
  end

  // Ownership next-state: round-robin from IDLE, locked bursts, park, handover
  always_comb begin
    owner_nxt       = owner;
    last_served_nxt = last_served;
    burst_clr       = 1'b0;
    burst_inc       = 1'b0;
    case (owner)
      ST_IDLE: begin
        if (req0 && req1) owner_nxt = last_served ? ST_OWN0 : ST_OWN1;
        else if (req0)    owner_nxt = ST_OWN0;
        else if (req1)    owner_nxt = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (own_req) begin
          if (own_lock && !burst_limit) begin
            burst_inc = 1'b1;
          end else begin
            // Burst ends; the limit only forces a handover when someone waits
            burst_clr = 1'b1;
            if (oth_req) begin
              owner_nxt       = oth_state;
              last_served_nxt = own_is1;
            end
          end
        end else begin
          burst_clr       = 1'b1;
          last_served_nxt = own_is1;
          owner_nxt       = oth_req ? oth_state : ST_IDLE;
        end
      end
      default: owner_nxt = ST_IDLE;
    endcase
  end

  // State register plus the one-cycle read-return tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= ST_IDLE;
      last_served <= 1'b1;
      rd_pend     <= 1'b0;
      rd_tag      <= 1'b0;
    end else begin
      owner       <= owner_nxt;
      last_served <= last_served_nxt;
      rd_pend     <= mem_en & ~mem_wr;
      rd_tag      <= gnt1;
    end
  end

  assign rvalid0 = rd_pend & ~rd_tag;
  assign rvalid1 = rd_pend & rd_tag;
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

  dm_arb_burst_ctr #(
    .MAX_BURST(MAX_BURST)
  ) u_burst_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (burst_clr),
    .inc      (burst_inc),
    .at_limit (burst_limit)
  );

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - scoreboard bench for dm_arbiter against a behavioural model
module tb_dm_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 0, lock0 = 0, wr0 = 0, req1 = 0, lock1 = 0, wr1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_wr;
  logic [DW-1:0] rdata0, rdata1, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .lock0(lock0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .lock1(lock1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] seed(input logic [7:0] a);
    return a ^ 8'hB5;
  endfunction

  // Single-port memory: unwritten locations return seed(addr), so 0x10 reads 0xA5
  logic [DW-1:0] mem [256];
  bit            mem_vld [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr) begin
        mem[mem_addr[7:0]]     <= mem_wdata;
        mem_vld[mem_addr[7:0]] <= 1'b1;
      end else begin
        mem_rdata <= mem_vld[mem_addr[7:0]] ? mem[mem_addr[7:0]] : seed(mem_addr[7:0]);
      end
    end
  end

  typedef struct { bit req; bit lock; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } cmd_t;
  typedef struct { int cyc; int port; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } xfer_t;
  typedef struct { int cyc; int port; logic [DW-1:0] data; } rd_t;

  cmd_t  cq0[$], cq1[$];
  xfer_t exp_x[$];
  rd_t   exp_r[$];
  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model: owner -1 means nobody, burst counts transfers of the current lock
  int m_owner = -1, m_last = 1, m_burst = 0;
  bit m_pend = 0;
  int m_pend_port = 0;
  logic [DW-1:0] m_pend_data = '0;
  logic [DW-1:0] ref_mem [256];
  bit            ref_vld [256];

  function automatic cmd_t mk(input bit lock, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c.req = 1'b1; c.lock = lock; c.wr = wr; c.addr = a; c.wdata = d;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    return mk($urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 65535)), DW'($urandom_range(0, 255)));
  endfunction

  // One clock: drive inputs, predict this cycle's outputs, advance the model
  task automatic step(input bit do_rst, output int gp);
    cmd_t c0, c1, c;
    bit rq[2];
    bit lk[2];
    int o;
    c0 = '{0, 0, 0, '0, '0};
    c1 = '{0, 0, 0, '0, '0};
    gp = -1;
    @(posedge clk);
    #1;
    cyc++;
    if (!do_rst && cq0.size() > 0) c0 = cq0[0];
    if (!do_rst && cq1.size() > 0) c1 = cq1[0];
    rst_n = !do_rst;
    req0 = c0.req; lock0 = c0.lock; wr0 = c0.wr; addr0 = c0.addr; wdata0 = c0.wdata;
    req1 = c1.req; lock1 = c1.lock; wr1 = c1.wr; addr1 = c1.addr; wdata1 = c1.wdata;
    if (do_rst) begin
      m_owner = -1; m_last = 1; m_burst = 0; m_pend = 0;
      cq0.delete(); cq1.delete();
      return;
    end
    if (m_pend) exp_r.push_back('{cyc, m_pend_port, m_pend_data});
    m_pend = 0;
    rq[0] = c0.req; rq[1] = c1.req;
    lk[0] = c0.lock; lk[1] = c1.lock;
    if (m_owner >= 0 && rq[m_owner]) gp = m_owner;
    if (gp >= 0) begin
      c = (gp == 1) ? c1 : c0;
      exp_x.push_back('{cyc, gp, c.wr, c.addr, c.wdata});
      if (c.wr) begin
        ref_mem[c.addr[7:0]] = c.wdata;
        ref_vld[c.addr[7:0]] = 1'b1;
      end else begin
        m_pend = 1; m_pend_port = gp;
        m_pend_data = ref_vld[c.addr[7:0]] ? ref_mem[c.addr[7:0]] : seed(c.addr[7:0]);
      end
      if (gp == 1) void'(cq1.pop_front());
      else         void'(cq0.pop_front());
    end
    if (m_owner < 0) begin
      if (rq[0] && rq[1]) m_owner = 1 - m_last;
      else if (rq[0])     m_owner = 0;
      else if (rq[1])     m_owner = 1;
    end else begin
      o = m_owner;
      if (gp == o) begin
        m_burst++;
        if (!(lk[o] && m_burst < MB)) begin
          m_burst = 0;
          if (rq[1-o]) begin m_last = o; m_owner = 1 - o; end
        end
      end else begin
        m_burst = 0; m_last = o;
        m_owner = rq[1-o] ? 1 - o : -1;
      end
    end
  endtask

  // Run until both requesters and the pending read have drained, bounded
  task automatic drain();
    int g;
    int n;
    n = 0;
    while ((cq0.size() > 0 || cq1.size() > 0 || m_pend) && n < 200) begin
      step(0, g);
      n++;
    end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d/%0d commands still queued after %0d cycles, required 0", cq0.size(), cq1.size(), n);
    end
    step(0, g);
    step(0, g);
  endtask

  xfer_t mx;
  rd_t   mr;

  // Monitor: compare DUT outputs mid-cycle against the scoreboard queues
  always @(negedge clk) begin
    if (!rst_n) begin
      vectors++;
      if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_wr} != 6'b0 || mem_addr != '0 || mem_wdata != '0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc %0d: gnt=%b%b rvalid=%b%b en=%b wr=%b addr=%h wdata=%h, required all 0",
                 cyc, gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_wr, mem_addr, mem_wdata);
      end
    end else begin
      while (exp_x.size() > 0 && exp_x[0].cyc < cyc) begin
        mx = exp_x.pop_front();
        vectors++; miscompares++;
        $display("FAIL missing_grant cyc %0d: no transfer seen, required port %0d in cyc %0d", cyc, mx.port, mx.cyc);
      end
      while (exp_r.size() > 0 && exp_r[0].cyc < cyc) begin
        mr = exp_r.pop_front();
        vectors++; miscompares++;
        $display("FAIL missing_rvalid cyc %0d: no rvalid seen, required port %0d in cyc %0d", cyc, mr.port, mr.cyc);
      end
      if (mem_en || gnt0 || gnt1) begin
        vectors++;
        if (exp_x.size() == 0 || exp_x[0].cyc != cyc) begin
          miscompares++;
          $display("FAIL spurious_grant cyc %0d: gnt=%b%b en=%b, required no transfer", cyc, gnt0, gnt1, mem_en);
        end else begin
          mx = exp_x.pop_front();
          if (gnt0 != (mx.port == 0) || gnt1 != (mx.port == 1) || !mem_en || mem_wr != mx.wr ||
              mem_addr != mx.addr || mem_wdata != mx.wdata) begin
            miscompares++;
            $display("FAIL transfer cyc %0d: gnt=%b%b en=%b wr=%b addr=%h wdata=%h, required port %0d wr=%b addr=%h wdata=%h",
                     cyc, gnt0, gnt1, mem_en, mem_wr, mem_addr, mem_wdata, mx.port, mx.wr, mx.addr, mx.wdata);
          end
        end
      end else if (exp_x.size() > 0 && exp_x[0].cyc == cyc) begin
        mx = exp_x.pop_front();
        vectors++; miscompares++;
        $display("FAIL missing_grant cyc %0d: no transfer seen, required port %0d", cyc, mx.port);
      end
      if (rvalid0 || rvalid1) begin
        vectors++;
        if (exp_r.size() == 0 || exp_r[0].cyc != cyc) begin
          miscompares++;
          $display("FAIL spurious_rvalid cyc %0d: rvalid=%b%b, required none", cyc, rvalid0, rvalid1);
        end else begin
          mr = exp_r.pop_front();
          if (rvalid0 != (mr.port == 0) || rvalid1 != (mr.port == 1) ||
              ((mr.port == 0) ? rdata0 : rdata1) != mr.data) begin
            miscompares++;
            $display("FAIL read_return cyc %0d: rvalid=%b%b rdata0=%h rdata1=%h, required port %0d data %h",
                     cyc, rvalid0, rvalid1, rdata0, rdata1, mr.port, mr.data);
          end
        end
      end else if (exp_r.size() > 0 && exp_r[0].cyc == cyc) begin
        mr = exp_r.pop_front();
        vectors++; miscompares++;
        $display("FAIL missing_rvalid cyc %0d: no rvalid seen, required port %0d data %h", cyc, mr.port, mr.data);
      end
    end
  end

  initial begin
    int g;
    int n;
    for (int i = 0; i < 256; i++) ref_vld[i] = 1'b0;
    repeat (3) step(1, g);

    // Single read from the core at 0x0010
    cq0.push_back(mk(0, 0, 16'h0010, 8'h00));
    drain();

    // Both requesting, unlocked: strict alternation
    for (int i = 0; i < 8; i++) begin
      cq0.push_back(mk(0, 0, AW'(16'h0200 + i), 8'h00));
      cq1.push_back(mk(0, 0, AW'(16'h0300 + i), 8'h00));
    end
    drain();

    // Locked burst from the core against a waiting host: limit forces release
    for (int i = 0; i < 6; i++) cq0.push_back(mk(1, 1, AW'(16'h0040 + i), DW'(8'h10 + i)));
    for (int i = 0; i < 2; i++) cq1.push_back(mk(0, 0, AW'(16'h0040 + i), 8'h00));
    drain();

    // Host write then read-back of 0x0100
    cq1.push_back(mk(0, 1, 16'h0100, 8'h3C));
    cq1.push_back(mk(0, 0, 16'h0100, 8'h00));
    drain();

    // Core alone, six back-to-back reads, one of them locked past the limit
    for (int i = 0; i < 6; i++) cq0.push_back(mk(i < 5, 0, AW'(16'h0100 + i), 8'h00));
    drain();

    // Reset the cycle after a read grant, then both request: core must win
    cq0.push_back(mk(0, 0, 16'h0010, 8'h00));
    n = 0;
    g = -1;
    while (g != 0 && n < 20) begin
      step(0, g);
      n++;
    end
    vectors++;
    if (g != 0) begin
      miscompares++;
      $display("FAIL reset_setup: no core grant within %0d cycles, required one", n);
    end
    step(1, g);
    cq0.push_back(mk(0, 0, 16'h0011, 8'h00));
    cq1.push_back(mk(0, 0, 16'h0012, 8'h00));
    drain();

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      if (cq0.size() == 0 && $urandom_range(0, 99) < 60) cq0.push_back(rnd_cmd());
      if (cq1.size() == 0 && $urandom_range(0, 99) < 60) cq1.push_back(rnd_cmd());
      step(0, g);
    end
    drain();

    vectors++;
    if (exp_x.size() != 0 || exp_r.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: %0d transfers and %0d reads unobserved, required 0", exp_x.size(), exp_r.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter that lets the processor core and a host loader share the single-port data memory of the matrix-multiplier design. It serialises their accesses onto one memory port using round-robin arbitration, optional locked bursts with a hard burst limit, and per-requester read-return routing. It sits between the requesters and the data memory, and replaces direct core-to-memory wiring.

## Interface

- ADDR_WIDTH, 16, memory address width
- DATA_WIDTH, 8, memory data width
- MAX_BURST, 4, maximum consecutive locked transfers before forced release (≥1)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- reqN  in  1  requester N (N=0 core, N=1 host) access request; hold with command stable until granted
- lockN  in  1  request to keep ownership after this transfer
- wrN  in  1  1 = write, 0 = read
- addrN  in  ADDR_WIDTH  access address
- wdataN  in  DATA_WIDTH  write data
- gntN  out  1  transfer accepted this cycle
- rvalidN  out  1  read data for N valid this cycle
- rdataN  out  DATA_WIDTH  read data (mem_rdata broadcast), qualified by rvalidN
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after a read

## Operation

- Owner FSM states are IDLE, OWN0, and OWN1. A transfer for N occurs in any cycle with owner==N and reqN=1.
- gntN = reqN & (owner==N), combinational. The mem_* outputs are a combinational mux of the owner's command. mem_en = gnt0|gnt1. mem_wr = mem_en & wr of owner.
- IDLE: if any request, go to OWN of the round-robin winner. The winner is the requester not equal to last_served; the other requester wins only if it is the sole request. Otherwise stay in IDLE.
- OWNx with a transfer:
  - burst_cnt increments.
  - Stay in OWNx if lockx=1 and burst_cnt+1 < MAX_BURST.
  - Otherwise go to the other OWN if the other requester is requesting (burst_cnt←0, last_served←x).
  - Otherwise stay in OWNx (park) with burst_cnt←0.
- OWNx without a transfer (reqx=0): go to the other OWN if the other requester is requesting, else IDLE. burst_cnt←0, last_served←x.
- The forced release at MAX_BURST applies only when the other requester is waiting.
- Read return: on a read transfer, register rd_pend=1 and rd_tag=owner. The next cycle asserts rvalid[rd_tag] for one cycle. Writes produce no rvalid.
- Reset values:
  - owner=IDLE, last_served=1 (so P0 wins first), burst_cnt=0, rd_pend=0.
  - All gnt, rvalid, and mem_en outputs are 0.
  - mem_addr, mem_wdata, and mem_wr are 0 in IDLE.
- Reset mid-operation aborts ownership and suppresses any pending rvalid.

## Timing

- Arbitration latency is 1 cycle from IDLE: reqN rising in cycle t gives gntN in cycle t+1.
- A parked or locked owner gets back-to-back grants with no bubble.
- An ownership switch costs no bubble when the other requester is already waiting.
- Read latency: rvalidN arrives exactly 1 cycle after gntN of the read.
- A requester may change its command in the cycle after gnt. With reqN held, the next command is taken the following cycle if ownership is retained.
- Simultaneous requests from IDLE resolve by last_served. Simultaneous unlocked requests alternate every cycle.

## Structure

- Shared package dm_arb_pkg holds the owner state encoding (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10) and a burst-counter width function, clog2(MAX_BURST)+1.
- One sub-module, dm_arb_burst_ctr: the burst counter with clear, increment, and limit-reached output. Everything else stays in dm_arbiter.

## Test plan

- Reset, then req0 read at 0x0010 in cycle 0 with memory returning 0xA5 → gnt0 and mem_en in cycle 1 with mem_addr=0x0010; rvalid0=1 with rdata0=0xA5 in cycle 2; rvalid1 stays 0.
- After reset, req0 and req1 both continuously asserted, unlocked → grants go 0,1,0,1,… starting cycle 1, one grant per cycle.
- MAX_BURST=4, req0+lock0 continuous, req1 asserted → exactly 4 consecutive gnt0, then gnt1 on the next cycle.
- P1 writes 0x3C to 0x0100, then reads 0x0100 → mem_wr=1 on the write grant only; rvalid1 with rdata1=0x3C one cycle after the read grant; no rvalid0.
- P0 alone issues 6 back-to-back reads → gnt0 on 6 consecutive cycles after the first arbitration cycle, with 6 consecutive rvalid0.
- rst_n asserted the cycle after a read grant → all outputs 0 immediately, no rvalid; after release, P0 wins first again.
